// File: rtl/rs_alu_station_if.sv
// rs_alu_station bus definitions.
// rs_alu_pkg carries the datapath widths shared with the rest of the back end.
// rs_alu_station_if groups the flush, dispatch, CDB and ALU-issue signals.
// The master side (dispatch/commit logic and rs_alu) drives requests.
// The slave side (the reservation station) drives disp_rdy_o and alu_o.

package rs_alu_pkg;
    localparam int XLEN         = 32;
    localparam int ALU_OP_WIDTH = 4;
endpackage

interface rs_alu_station_if #(
    parameter int TAG_W = 4
) ();
    // Issue payload to rs_alu, packed in the order {rs_v1, rs_v2, rs_op, rs_tag, rs_valid}
    typedef struct packed {
        logic [rs_alu_pkg::XLEN-1:0]         rs_v1;
        logic [rs_alu_pkg::XLEN-1:0]         rs_v2;
        logic [rs_alu_pkg::ALU_OP_WIDTH-1:0] rs_op;
        logic [TAG_W-1:0]                    rs_tag;
        logic                                rs_valid;
    } rs_alu_struct_o;

    logic                                flush_i;
    logic                                disp_valid_i;
    logic                                disp_rdy_o;
    logic [rs_alu_pkg::ALU_OP_WIDTH-1:0] disp_op_i;
    logic [TAG_W-1:0]                    disp_tag_i;
    logic                                disp_r1_i;
    logic [rs_alu_pkg::XLEN-1:0]         disp_v1_i;
    logic [TAG_W-1:0]                    disp_q1_i;
    logic                                disp_r2_i;
    logic [rs_alu_pkg::XLEN-1:0]         disp_v2_i;
    logic [TAG_W-1:0]                    disp_q2_i;
    logic                                cdb_valid_i;
    logic [TAG_W-1:0]                    cdb_tag_i;
    logic [rs_alu_pkg::XLEN-1:0]         cdb_value_i;
    logic                                alu_rdy_i;
    rs_alu_struct_o                      alu_o;

    modport master (
        output flush_i, disp_valid_i, disp_op_i, disp_tag_i,
               disp_r1_i, disp_v1_i, disp_q1_i,
               disp_r2_i, disp_v2_i, disp_q2_i,
               cdb_valid_i, cdb_tag_i, cdb_value_i, alu_rdy_i,
        input  disp_rdy_o, alu_o
    );

    modport slave (
        input  flush_i, disp_valid_i, disp_op_i, disp_tag_i,
               disp_r1_i, disp_v1_i, disp_q1_i,
               disp_r2_i, disp_v2_i, disp_q2_i,
               cdb_valid_i, cdb_tag_i, cdb_value_i, alu_rdy_i,
        output disp_rdy_o, alu_o
    );
endinterface

// File: rtl/rs_alu_station.sv
// rs_alu_station: reservation station in front of the rs_alu functional unit.
// Holds DEPTH dispatched ALU ops, snoops the CDB for pending operands and
// presents one fully-ready op per cycle on alu_o. An entry is freed when
// rs_alu accepts it (alu_rdy_i high while alu_o.rs_valid).
// Optional feature macro: RS_ALU_AGE_SELECT_EN
//   defined   - oldest ready entry issues first (per-entry saturating age)
//   undefined - lowest-index ready entry issues first

module rs_alu_station #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input logic            clk,
    input logic            rst_n,
    rs_alu_station_if.slave bus
);
    import rs_alu_pkg::*;

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Control state (reset)
    logic [DEPTH-1:0] busy;
    logic             hold_vld;
    logic [IDX_W-1:0] hold_idx;

    // Payload state (not reset, qualified by busy)
    logic [ALU_OP_WIDTH-1:0] op_q  [DEPTH];
    logic [TAG_W-1:0]        tag_q [DEPTH];
    logic [DEPTH-1:0]        r1_q;
    logic [DEPTH-1:0]        r2_q;
    logic [XLEN-1:0]         v1_q  [DEPTH];
    logic [XLEN-1:0]         v2_q  [DEPTH];
    logic [TAG_W-1:0]        q1_q  [DEPTH];
    logic [TAG_W-1:0]        q2_q  [DEPTH];

`ifdef RS_ALU_AGE_SELECT_EN
    logic [IDX_W-1:0] age_q [DEPTH];
    logic [IDX_W-1:0] best_age;
`endif

    // Derived combinational signals
    logic [DEPTH-1:0] ready;
    logic             disp_rdy;
    logic [IDX_W-1:0] free_idx;
    logic             sel_valid;
    logic [IDX_W-1:0] sel_idx;
    logic             accept;
    logic             retire;
    logic             in1_r;
    logic             in2_r;
    logic [XLEN-1:0]  in1_v;
    logic [XLEN-1:0]  in2_v;

    assign ready    = busy & r1_q & r2_q;
    assign disp_rdy = ~&busy;
    assign accept   = bus.disp_valid_i && disp_rdy && !bus.flush_i;
    assign retire   = sel_valid && bus.alu_rdy_i && !bus.flush_i;

    assign bus.disp_rdy_o = disp_rdy;

    // Incoming operands may be completed by a CDB broadcast in the same cycle
    assign in1_r = bus.disp_r1_i || (bus.cdb_valid_i && (bus.disp_q1_i == bus.cdb_tag_i));
    assign in2_r = bus.disp_r2_i || (bus.cdb_valid_i && (bus.disp_q2_i == bus.cdb_tag_i));
    assign in1_v = bus.disp_r1_i ? bus.disp_v1_i : bus.cdb_value_i;
    assign in2_v = bus.disp_r2_i ? bus.disp_v2_i : bus.cdb_value_i;

    // Lowest-index free entry receives the next dispatch
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = IDX_W'(i);
        end
    end

    // Issue selection; a stalled entry stays selected until rs_alu takes it
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
`ifdef RS_ALU_AGE_SELECT_EN
        best_age  = '0;
`endif
        if (hold_vld && ready[hold_idx]) begin
            sel_valid = 1'b1;
            sel_idx   = hold_idx;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_ALU_AGE_SELECT_EN
                // Strictly greater keeps ties on the lowest index
                if (ready[i] && (!sel_valid || (age_q[i] > best_age))) begin
                    sel_valid = 1'b1;
                    sel_idx   = IDX_W'(i);
                    best_age  = age_q[i];
                end
`else
                if (ready[i] && !sel_valid) begin
                    sel_valid = 1'b1;
                    sel_idx   = IDX_W'(i);
                end
`endif
            end
        end
    end

    // Drive the issue payload; all fields are zero when nothing is ready
    always_comb begin
        bus.alu_o = '0;
        if (sel_valid) begin
            bus.alu_o.rs_v1    = v1_q[sel_idx];
            bus.alu_o.rs_v2    = v2_q[sel_idx];
            bus.alu_o.rs_op    = op_q[sel_idx];
            bus.alu_o.rs_tag   = tag_q[sel_idx];
            bus.alu_o.rs_valid = 1'b1;
        end
    end

    // Occupancy, stall-hold and age bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            busy     <= '0;
            hold_vld <= 1'b0;
            hold_idx <= '0;
`ifdef RS_ALU_AGE_SELECT_EN
            for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
`endif
        end else if (bus.flush_i) begin
            busy     <= '0;
            hold_vld <= 1'b0;
        end else begin
            hold_vld <= sel_valid && !bus.alu_rdy_i;
            hold_idx <= sel_idx;
            // Retired and dispatched entries never coincide: a retiring entry is still busy
            if (retire) busy[sel_idx] <= 1'b0;
            if (accept) busy[free_idx] <= 1'b1;
`ifdef RS_ALU_AGE_SELECT_EN
            if (accept) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (busy[i] && (age_q[i] != IDX_W'(DEPTH - 1))) age_q[i] <= age_q[i] + 1'b1;
                end
                age_q[free_idx] <= '0;
            end
`endif
        end
    end

    // Entry payload: dispatch write and CDB operand capture
    always_ff @(posedge clk) begin
        // NOTE: payload storage has no reset; busy gates every use, so stale contents are never visible.
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && (free_idx == IDX_W'(i))) begin
                op_q[i]  <= bus.disp_op_i;
                tag_q[i] <= bus.disp_tag_i;
                r1_q[i]  <= in1_r;
                v1_q[i]  <= in1_v;
                q1_q[i]  <= bus.disp_q1_i;
                r2_q[i]  <= in2_r;
                v2_q[i]  <= in2_v;
                q2_q[i]  <= bus.disp_q2_i;
            end else if (busy[i] && bus.cdb_valid_i && !(retire && (sel_idx == IDX_W'(i)))) begin
                if (!r1_q[i] && (q1_q[i] == bus.cdb_tag_i)) begin
                    r1_q[i] <= 1'b1;
                    v1_q[i] <= bus.cdb_value_i;
                end
                if (!r2_q[i] && (q2_q[i] == bus.cdb_tag_i)) begin
                    r2_q[i] <= 1'b1;
                    v2_q[i] <= bus.cdb_value_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_alu_station.sv
// Directed self-checking bench for rs_alu_station (DEPTH=4, TAG_W=4).
// Expected issue order in the stall test follows RS_ALU_AGE_SELECT_EN.

module tb_rs_alu_station;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;

`ifdef RS_ALU_AGE_SELECT_EN
    localparam logic [3:0] FIRST_TAG  = 4'd1;
    localparam logic [3:0] SECOND_TAG = 4'd2;
`else
    localparam logic [3:0] FIRST_TAG  = 4'd2;
    localparam logic [3:0] SECOND_TAG = 4'd1;
`endif

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    rs_alu_station_if #(.TAG_W(4)) bus ();

    rs_alu_station #(.DEPTH(4), .TAG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush_i      = 1'b0;
        bus.disp_valid_i = 1'b0;
        bus.disp_op_i    = '0;
        bus.disp_tag_i   = '0;
        bus.disp_r1_i    = 1'b0;
        bus.disp_v1_i    = '0;
        bus.disp_q1_i    = '0;
        bus.disp_r2_i    = 1'b0;
        bus.disp_v2_i    = '0;
        bus.disp_q2_i    = '0;
        bus.cdb_valid_i  = 1'b0;
        bus.cdb_tag_i    = '0;
        bus.cdb_value_i  = '0;
    endtask

    task automatic set_disp(input logic [3:0] op, input logic [3:0] tag,
                            input logic r1, input logic [31:0] v1, input logic [3:0] q1,
                            input logic r2, input logic [31:0] v2, input logic [3:0] q2);
        bus.disp_valid_i = 1'b1;
        bus.disp_op_i    = op;
        bus.disp_tag_i   = tag;
        bus.disp_r1_i    = r1;
        bus.disp_v1_i    = v1;
        bus.disp_q1_i    = q1;
        bus.disp_r2_i    = r2;
        bus.disp_v2_i    = v2;
        bus.disp_q2_i    = q2;
    endtask

    task automatic set_cdb(input logic [3:0] tag, input logic [31:0] value);
        bus.cdb_valid_i = 1'b1;
        bus.cdb_tag_i   = tag;
        bus.cdb_value_i = value;
    endtask

    task automatic clr_cdb();
        bus.cdb_valid_i = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle();
        bus.alu_rdy_i = 1'b0;

        // ---- 1: reset state, then reset in the middle of operation
        #12;
        check("rst_valid", 64'(bus.alu_o.rs_valid), 64'd0);
        check("rst_rdy",   64'(bus.disp_rdy_o),     64'd1);
        check("rst_alu_o", 64'(bus.alu_o.rs_tag) | 64'(bus.alu_o.rs_v1), 64'd0);
        rst_n = 1'b1;
        set_disp(OP_ADD, 4'd9,  1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0); step();
        set_disp(OP_ADD, 4'd10, 1'b1, 32'd2, 4'd0, 1'b1, 32'd2, 4'd0); step();
        set_disp(OP_ADD, 4'd11, 1'b1, 32'd3, 4'd0, 1'b1, 32'd3, 4'd0); step();
        idle();
        check("fill_valid", 64'(bus.alu_o.rs_valid), 64'd1);
        check("fill_tag",   64'(bus.alu_o.rs_tag),   64'd9);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(bus.alu_o.rs_valid), 64'd0);
        check("midrst_rdy",   64'(bus.disp_rdy_o),     64'd1);
        check("midrst_tag",   64'(bus.alu_o.rs_tag),   64'd0);
        rst_n = 1'b1;
        step();
        step();
        check("postrst_valid", 64'(bus.alu_o.rs_valid), 64'd0);
        check("postrst_rdy",   64'(bus.disp_rdy_o),     64'd1);

        // ---- 2: both operands ready, issue after one cycle
        bus.alu_rdy_i = 1'b1;
        set_disp(OP_ADD, 4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
        step();
        idle();
        check("add_valid", 64'(bus.alu_o.rs_valid), 64'd1);
        check("add_v1",    64'(bus.alu_o.rs_v1),    64'd5);
        check("add_v2",    64'(bus.alu_o.rs_v2),    64'd7);
        check("add_op",    64'(bus.alu_o.rs_op),    64'(OP_ADD));
        check("add_tag",   64'(bus.alu_o.rs_tag),   64'd3);
        step();
        check("add_freed_valid", 64'(bus.alu_o.rs_valid), 64'd0);
        check("add_freed_rdy",   64'(bus.disp_rdy_o),     64'd1);

        // ---- 3: operand 1 waits for a CDB broadcast
        set_disp(OP_SUB, 4'd4, 1'b0, 32'd0, 4'd2, 1'b1, 32'd1, 4'd0);
        step();
        idle();
        check("wait_c1", 64'(bus.alu_o.rs_valid), 64'd0);
        step();
        check("wait_c2", 64'(bus.alu_o.rs_valid), 64'd0);
        set_cdb(4'd2, 32'h10);
        step();
        clr_cdb();
        check("cdb_valid", 64'(bus.alu_o.rs_valid), 64'd1);
        check("cdb_v1",    64'(bus.alu_o.rs_v1),    64'h10);
        check("cdb_v2",    64'(bus.alu_o.rs_v2),    64'd1);
        check("cdb_op",    64'(bus.alu_o.rs_op),    64'(OP_SUB));
        check("cdb_tag",   64'(bus.alu_o.rs_tag),   64'd4);
        step();
        check("cdb_freed", 64'(bus.alu_o.rs_valid), 64'd0);

        // ---- 4: dispatch bypass of a same-cycle broadcast
        set_disp(OP_AND, 4'd5, 1'b1, 32'd2, 4'd0, 1'b0, 32'd0, 4'd6);
        set_cdb(4'd6, 32'hAB);
        step();
        idle();
        check("byp_valid", 64'(bus.alu_o.rs_valid), 64'd1);
        check("byp_v1",    64'(bus.alu_o.rs_v1),    64'd2);
        check("byp_v2",    64'(bus.alu_o.rs_v2),    64'hAB);
        check("byp_tag",   64'(bus.alu_o.rs_tag),   64'd5);
        step();
        check("byp_freed", 64'(bus.alu_o.rs_valid), 64'd0);

        // ---- 5: full station, dropped 5th dispatch, free after issue, flush
        for (int i = 0; i < 4; i++) begin
            set_disp(OP_ADD, 4'(i + 1), 1'b0, 32'd0, 4'(9 + i), 1'b1, 32'(i), 4'd0);
            step();
        end
        idle();
        check("full_rdy",   64'(bus.disp_rdy_o),     64'd0);
        check("full_valid", 64'(bus.alu_o.rs_valid), 64'd0);
        set_disp(OP_ADD, 4'd8, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
        step();
        idle();
        check("fifth_rdy",   64'(bus.disp_rdy_o),     64'd0);
        check("fifth_valid", 64'(bus.alu_o.rs_valid), 64'd0);
        set_cdb(4'd11, 32'h33);
        step();
        clr_cdb();
        check("one_done_valid", 64'(bus.alu_o.rs_valid), 64'd1);
        check("one_done_tag",   64'(bus.alu_o.rs_tag),   64'd3);
        check("one_done_v1",    64'(bus.alu_o.rs_v1),    64'h33);
        check("one_done_v2",    64'(bus.alu_o.rs_v2),    64'd2);
        check("one_done_rdy",   64'(bus.disp_rdy_o),     64'd0);
        step();
        check("after_issue_rdy",   64'(bus.disp_rdy_o),     64'd1);
        check("after_issue_valid", 64'(bus.alu_o.rs_valid), 64'd0);
        set_disp(OP_ADD, 4'd12, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
        bus.flush_i = 1'b1;
        step();
        idle();
        check("flush_rdy",   64'(bus.disp_rdy_o),     64'd1);
        check("flush_valid", 64'(bus.alu_o.rs_valid), 64'd0);
        set_cdb(4'd9, 32'h44);
        step();
        clr_cdb();
        check("flush_gone", 64'(bus.alu_o.rs_valid), 64'd0);

        // ---- 6: stalled issue with two ready entries, older one at the higher index
        set_disp(OP_ADD, 4'd9, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0);
        step();
        set_disp(OP_SUB, 4'd1, 1'b0, 32'd0, 4'd14, 1'b1, 32'h21, 4'd0);
        step();
        check("stall_pre_valid", 64'(bus.alu_o.rs_valid), 64'd0);
        bus.alu_rdy_i = 1'b0;
        set_disp(OP_AND, 4'd2, 1'b0, 32'd0, 4'd14, 1'b1, 32'h22, 4'd0);
        step();
        idle();
        set_cdb(4'd14, 32'h55);
        step();
        clr_cdb();
        check("stall_c0_valid", 64'(bus.alu_o.rs_valid), 64'd1);
        check("stall_c0_tag",   64'(bus.alu_o.rs_tag),   64'(FIRST_TAG));
        check("stall_c0_v1",    64'(bus.alu_o.rs_v1),    64'h55);
        step();
        check("stall_c1_tag", 64'(bus.alu_o.rs_tag), 64'(FIRST_TAG));
        step();
        check("stall_c2_tag", 64'(bus.alu_o.rs_tag), 64'(FIRST_TAG));
        bus.alu_rdy_i = 1'b1;
        step();
        check("second_valid", 64'(bus.alu_o.rs_valid), 64'd1);
        check("second_tag",   64'(bus.alu_o.rs_tag),   64'(SECOND_TAG));
        check("second_v1",    64'(bus.alu_o.rs_v1),    64'h55);
        step();
        check("drained_valid", 64'(bus.alu_o.rs_valid), 64'd0);
        check("drained_rdy",   64'(bus.disp_rdy_o),     64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
